reg_write_arbiter: RTL and testbench

REG_WRITE_ARBITER -- requirements
Module: reg_write_arbiter

---
 rtl/reg_ctrl_pkg.sv | 19 +
 rtl/reg_write_arbiter_if.sv | 29 ++
 rtl/rr_arbiter.sv | 33 +++
 rtl/reg_write_arbiter.sv | 91 +++++++++
 tb/tb_reg_write_arbiter.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/reg_ctrl_pkg.sv
// rtl/reg_ctrl_pkg.sv - shared state encoding and default sizes for the register write path
package reg_ctrl_pkg;

    localparam int DEF_NREQ   = 3;
    localparam int DEF_DATA_W = 4;
    localparam int DEF_NREG   = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LATCH = 2'd1,
        WRITE = 2'd2
    } state_t;

    // Index width for n items; a single item still needs one bit
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/reg_write_arbiter_if.sv
// rtl/reg_write_arbiter_if.sv - requester and register-bank signals of the write arbiter
interface reg_write_arbiter_if
    import reg_ctrl_pkg::*;
#(
    parameter int NREQ   = DEF_NREQ,
    parameter int DATA_W = DEF_DATA_W,
    parameter int NREG   = DEF_NREG
);
    localparam int AW = idx_w(NREG);

    logic [NREQ-1:0]        req;
    logic [NREQ*AW-1:0]     req_addr;
    logic [NREQ*DATA_W-1:0] req_data;
    logic [NREQ-1:0]        gnt;
    logic [NREG-1:0]        enabling;
    logic [DATA_W-1:0]      wdata;
    logic                   busy;

    modport master (
        output req, req_addr, req_data,
        input  gnt, enabling, wdata, busy
    );

    modport slave (
        input  req, req_addr, req_data,
        output gnt, enabling, wdata, busy
    );

endinterface

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick starting after the last grant
module rr_arbiter
    import reg_ctrl_pkg::*;
#(
    parameter  int NREQ = DEF_NREQ,
    localparam int IW   = idx_w(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] win_oh,
    output logic [IW-1:0]   win_idx
);

    logic          found;
    logic [IW-1:0] cand;

    // Walk ptr+1, ptr+2, ... with wrap; the first active request wins
    always_comb begin
        win_oh  = '0;
        win_idx = '0;
        found   = 1'b0;
        cand    = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = IW'((int'(ptr) + k) % NREQ);
            if (!found && req[cand]) begin
                found        = 1'b1;
                win_oh[cand] = 1'b1;
                win_idx      = cand;
            end
        end
    end

endmodule

// File: rtl/reg_write_arbiter.sv
// rtl/reg_write_arbiter.sv - round-robin arbiter serialising requester writes onto a register bank
module reg_write_arbiter
    import reg_ctrl_pkg::*;
#(
    parameter int NREQ   = DEF_NREQ,
    parameter int DATA_W = DEF_DATA_W,
    parameter int NREG   = DEF_NREG
) (
    input  logic               clock,
    input  logic               reset_n,
    reg_write_arbiter_if.slave bus
);

    localparam int AW = idx_w(NREG);
    localparam int IW = idx_w(NREQ);

    state_t            state;
    logic [IW-1:0]     ptr;
    logic [AW-1:0]     cap_addr;
    logic [AW-1:0]     addr_arr [NREQ];
    logic [DATA_W-1:0] data_arr [NREQ];
    logic [NREQ-1:0]   win_oh;
    logic [IW-1:0]     win_idx;
    logic [NREG-1:0]   en_dec;

    // Unpack the per-requester address and data fields
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            addr_arr[i] = bus.req_addr[i*AW +: AW];
            data_arr[i] = bus.req_data[i*DATA_W +: DATA_W];
        end
    end

    rr_arbiter #(.NREQ(NREQ)) u_rr (
        .req     (bus.req),
        .ptr     (ptr),
        .win_oh  (win_oh),
        .win_idx (win_idx)
    );

    // One-hot register select; an address past the last register selects nothing
    always_comb begin
        en_dec = '0;
        for (int r = 0; r < NREG; r++) begin
            if (cap_addr == AW'(r)) begin
                en_dec[r] = 1'b1;
            end
        end
    end

    // Arbitrate in IDLE/WRITE, grant and capture into LATCH, pulse the enable in WRITE
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            ptr          <= IW'(NREQ - 1);
            cap_addr     <= '0;
            bus.gnt      <= '0;
            bus.enabling <= '0;
            bus.wdata    <= '0;
            bus.busy     <= 1'b0;
        end else begin
            bus.gnt      <= '0;
            bus.enabling <= '0;
            case (state)
                IDLE, WRITE: begin
                    if (|bus.req) begin
                        state     <= LATCH;
                        bus.gnt   <= win_oh;
                        cap_addr  <= addr_arr[win_idx];
                        bus.wdata <= data_arr[win_idx];
                        ptr       <= win_idx;
                        bus.busy  <= 1'b1;
                    end else begin
                        state    <= IDLE;
                        bus.busy <= 1'b0;
                    end
                end
                LATCH: begin
                    state        <= WRITE;
                    bus.enabling <= en_dec;
                    bus.busy     <= 1'b1;
                end
                default: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reg_write_arbiter.sv
// tb/tb_reg_write_arbiter.sv - scoreboard bench for reg_write_arbiter
module tb_reg_write_arbiter;

    localparam int NREQ = 3;
    localparam int DW   = 4;
    localparam int NREG = 4;
    localparam int AW   = 2;

    typedef struct {
        int gc;
        int idx;
        int addr;
        int data;
    } wr_t;

    logic clock;
    logic reset_n;

    reg_write_arbiter_if #(.NREQ(NREQ), .DATA_W(DW), .NREG(NREG)) bus ();

    reg_write_arbiter #(.NREQ(NREQ), .DATA_W(DW), .NREG(NREG)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;

    wr_t q[$];
    int  cnt      = 0;
    int  last     = -10;
    int  ptr_m    = NREQ - 1;
    int  cur_data = 0;
    int  regs_exp [NREG];
    logic [DW-1:0] regs [NREG];

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Register bank stand-in: loads wdata on its enable
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int r = 0; r < NREG; r++) regs[r] <= '0;
        end else begin
            for (int r = 0; r < NREG; r++) if (bus.enabling[r]) regs[r] <= bus.wdata;
        end
    end

    // Monitor: compare outputs against the scoreboard, then predict the next cycle
    always @(negedge clock) begin : monitor
        int g_exp, e_exp, b_exp, w, a;
        cnt++;
        if (!reset_n) begin
            chk("rst_gnt", int'(bus.gnt), 0);
            chk("rst_enabling", int'(bus.enabling), 0);
            chk("rst_busy", int'(bus.busy), 0);
            chk("rst_wdata", int'(bus.wdata), 0);
            q.delete();
            last     = -10;
            ptr_m    = NREQ - 1;
            cur_data = 0;
            for (int r = 0; r < NREG; r++) regs_exp[r] = 0;
        end else begin
            g_exp = 0;
            e_exp = 0;
            b_exp = 0;
            if (q.size() > 0 && q[0].gc == cnt) begin
                g_exp    = 1 << q[0].idx;
                b_exp    = 1;
                cur_data = q[0].data;
            end
            if (q.size() > 0 && q[0].gc + 1 == cnt) begin
                if (q[0].addr < NREG) begin
                    e_exp = 1 << q[0].addr;
                    regs_exp[q[0].addr] = q[0].data;
                end
                b_exp = 1;
                void'(q.pop_front());
            end
            chk("gnt", int'(bus.gnt), g_exp);
            chk("enabling", int'(bus.enabling), e_exp);
            chk("busy", int'(bus.busy), b_exp);
            chk("wdata", int'(bus.wdata), cur_data);
            // A write takes two cycles from its grant; next grant no sooner than that
            if (bus.req != '0 && cnt + 1 >= last + 2) begin
                w = -1;
                for (int k = 1; k <= NREQ; k++) begin
                    a = (ptr_m + k) % NREQ;
                    if (w < 0 && bus.req[a]) w = a;
                end
                q.push_back('{gc: cnt + 1, idx: w,
                              addr: int'(bus.req_addr[w*AW +: AW]),
                              data: int'(bus.req_data[w*DW +: DW])});
                ptr_m = w;
                last  = cnt + 1;
            end
        end
    end

    task automatic tick(input bit drop);
        @(posedge clock);
        #2;
        if (drop) bus.req = bus.req & ~bus.gnt;
    endtask

    task automatic set_req(input int i, input int a, input int d);
        bus.req_addr[i*AW +: AW] = AW'(a);
        bus.req_data[i*DW +: DW] = DW'(d);
        bus.req[i] = 1'b1;
    endtask

    task automatic wait_gnt(input string name);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
            tick(1'b0);
            if (bus.gnt != '0) seen = 1'b1;
        end
        if (!seen) chk(name, 0, 1);
    endtask

    // Directed scenarios followed by a randomized phase
    initial begin
        reset_n      = 1'b1;
        bus.req      = '0;
        bus.req_addr = '0;
        bus.req_data = '0;
        #1 reset_n = 1'b0;
        #2;
        chk("init_gnt", int'(bus.gnt), 0);
        chk("init_enabling", int'(bus.enabling), 0);
        chk("init_busy", int'(bus.busy), 0);
        chk("init_wdata", int'(bus.wdata), 0);
        tick(1'b0);
        tick(1'b0);
        reset_n = 1'b1;

        // single request
        set_req(0, 2, 4'b1010);
        repeat (4) tick(1'b1);
        chk("single_reg2", int'(regs[2]), 4'b1010);

        // contention with requests held
        set_req(0, 0, 3);
        set_req(1, 1, 5);
        set_req(2, 2, 6);
        repeat (8) tick(1'b0);
        bus.req = '0;
        repeat (3) tick(1'b1);

        // requester 2 last, then duplicate target from 0 and 2
        set_req(2, 3, 7);
        repeat (4) tick(1'b1);
        set_req(0, 1, 4'b0001);
        set_req(2, 1, 4'b1111);
        repeat (8) tick(1'b1);
        chk("dup_reg1", int'(regs[1]), 4'b1111);

        // data change while the write is in flight
        set_req(1, 0, 9);
        wait_gnt("gnt_timeout_midwrite");
        bus.req = bus.req & ~bus.gnt;
        tick(1'b0);
        bus.req_data[1*DW +: DW] = 4'h2;
        repeat (3) tick(1'b1);
        chk("midwrite_reg0", int'(regs[0]), 9);

        // reset during LATCH
        bus.req = '0;
        set_req(0, 3, 12);
        wait_gnt("gnt_timeout_reset");
        reset_n = 1'b0;
        #1;
        chk("arst_gnt", int'(bus.gnt), 0);
        chk("arst_enabling", int'(bus.enabling), 0);
        chk("arst_busy", int'(bus.busy), 0);
        repeat (2) tick(1'b0);
        bus.req = '0;
        set_req(1, 2, 4);
        tick(1'b0);
        reset_n = 1'b1;
        repeat (4) tick(1'b1);
        chk("post_reset_reg2", int'(regs[2]), 4);
        chk("post_reset_reg3", int'(regs[3]), 0);

        // randomized traffic
        repeat (400) begin
            tick($urandom_range(0, 3) != 0);
            for (int i = 0; i < NREQ; i++) begin
                if (!bus.req[i] && $urandom_range(0, 2) == 0)
                    set_req(i, $urandom_range(0, NREG - 1), $urandom_range(0, 15));
            end
        end
        bus.req = '0;
        repeat (6) tick(1'b1);
        for (int r = 0; r < NREG; r++) chk("final_reg", int'(regs[r]), regs_exp[r]);
        chk("queue_drained", q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
